// File: rtl/rk4_clk_pkg.sv
// Shared types and constants for the RK4 programmable clock divider.
package rk4_clk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rk4_div_state_e;

  // Divisors below DIV_MIN mean "stopped".
  localparam int DIV_MIN       = 2;
  localparam int DIV_W_DEFAULT = 8;

endpackage

// File: rtl/rk4_clk_div_prog.sv
// Programmable glitch-free clock divider: divisor changes and stops only take
// effect on a period boundary, so clk_out never produces a runt pulse.
module rk4_clk_div_prog
  import rk4_clk_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DIV_RST = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             period_tick,
  output logic             div_pending,
  output logic             running,
  output logic [DIV_W-1:0] div_active
);

  rk4_div_state_e   state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_active_q;
  logic [DIV_W-1:0] div_shadow_q;
  logic             div_pending_q;
  logic             clk_out_q;
  logic             tick_q;
  logic             running_q;

  logic             boundary_d;
  logic             apply_d;
  logic [DIV_W-1:0] div_next_d;
  logic             go_d;

  // Valid/ready-free control: div_load is a one-cycle strobe, en is a level;
  // both are sampled on every clk_in edge and never back-pressured.
  always_comb begin
    boundary_d = (state_q == RUN) && (cnt_q == div_active_q - DIV_W'(1));
    apply_d    = div_pending_q && ((state_q == IDLE) || boundary_d);
    div_next_d = apply_d ? div_shadow_q : div_active_q;
    go_d       = en && (div_next_d >= DIV_W'(DIV_MIN));
  end

  // Outputs are decoded from the pre-edge phase, so the visible waveform
  // trails the internal counter by one cycle and is entirely flop-driven.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_active_q  <= DIV_W'(DIV_RST);
      div_shadow_q  <= DIV_W'(DIV_RST);
      div_pending_q <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      div_active_q <= div_next_d;
      if (div_load) begin
        div_shadow_q  <= div_in;
        div_pending_q <= 1'b1;
      end else if (apply_d) begin
        div_pending_q <= 1'b0;
      end

      running_q <= (state_q == RUN);
      clk_out_q <= (state_q == RUN) && (cnt_q < (div_active_q >> 1));
      tick_q    <= boundary_d;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (go_d) state_q <= RUN;
        end
        RUN: begin
          if (boundary_d) begin
            cnt_q <= '0;
            if (!go_d) state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
      endcase
    end
  end

  assign clk_out     = clk_out_q;
  assign period_tick = tick_q;
  assign div_pending = div_pending_q;
  assign running     = running_q;
  assign div_active  = div_active_q;

endmodule

// File: tb/tb_rk4_clk_div_prog.sv
// Self-checking bench for rk4_clk_div_prog against a period-level reference model.
module tb_rk4_clk_div_prog;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         clk_out;
  logic         period_tick;
  logic         div_pending;
  logic         running;
  logic [W-1:0] div_active;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue entry {clk, tick} per remaining phase of the
  // period currently being emitted.
  logic [1:0]   exp_q[$];
  bit           m_run;
  logic [W-1:0] m_active;
  logic [W-1:0] m_shadow;
  logic         m_pend;
  logic         exp_clk;
  logic         exp_tick;
  logic         exp_running;

  rk4_clk_div_prog #(.DIV_W(W), .DIV_RST(2)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .div_in      (div_in),
    .div_load    (div_load),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .div_pending (div_pending),
    .running     (running),
    .div_active  (div_active)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [11:0] obs_vec();
    return {clk_out, period_tick, running, div_pending, div_active};
  endfunction

  function automatic logic [11:0] exp_vec();
    return {exp_clk, exp_tick, exp_running, m_pend, m_active};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_run = 1'b0;
    m_active = 8'd2;
    m_shadow = 8'd2;
    m_pend = 1'b0;
    exp_clk = 1'b0;
    exp_tick = 1'b0;
    exp_running = 1'b0;
  endtask

  task automatic push_period(input logic [W-1:0] d);
    for (int i = 0; i < int'(d); i++)
      exp_q.push_back({(i < int'(d) / 2) ? 1'b1 : 1'b0, (i == int'(d) - 1) ? 1'b1 : 1'b0});
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return at edge+1.
  task automatic step(input logic e, input logic ld, input logic [W-1:0] d);
    logic       run_before;
    logic       apply;
    logic [1:0] o;
    en = e; div_load = ld; div_in = d;
    @(posedge clk_in);
    run_before = m_run;
    apply = 1'b0;
    o = 2'b00;
    if (run_before) begin
      if (exp_q.size() > 0) o = exp_q.pop_front();
      if (exp_q.size() == 0) begin
        apply = m_pend;
        if (apply) m_active = m_shadow;
        if (e && m_active >= 2) push_period(m_active);
        else m_run = 1'b0;
      end
    end else begin
      apply = m_pend;
      if (apply) m_active = m_shadow;
      if (e && m_active >= 2) begin
        m_run = 1'b1;
        push_period(m_active);
      end
    end
    if (ld) begin
      m_shadow = d;
      m_pend = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
    exp_clk = o[1];
    exp_tick = o[0];
    exp_running = run_before;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (obs_vec() !== 12'h002) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 12'h002);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_start_d2();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL start_d2 cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_load5();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, (i == 1), 8'd5);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL load5 cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_last_wins();
    bit found;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, (i == 1) || (i == 3), (i == 1) ? 8'd6 : 8'd9);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL last_wins cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run && exp_q.size() == 1) found = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL boundary_search got=timeout exp=boundary");
    end
    for (int i = 0; i < 25; i++) begin
      step(1'b1, (i == 0), 8'd3);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL load_on_boundary cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_en_drop();
    bit found;
    for (int i = 0; i < 6; i++) step(1'b1, (i == 0), 8'd8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run && m_active == 8 && exp_q.size() == 7) found = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL en_drop_phase1 got=timeout exp=phase1");
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL en_drop cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 20; i++) begin
      step((i < 3) || (i > 5), 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL en_cancel cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stop_div();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i == 2) || (i == 20) || (i == 30), (i == 2) ? 8'd1 : (i == 20) ? 8'd0 : 8'd4);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stop_div cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 8'd10);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_active == 10 && exp_clk) found = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    checks++;
    if (!found || clk_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup got=%b exp=1", clk_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 12'h002) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec(), 12'h002);
    end
    model_reset();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic         e;
    logic         ld;
    logic [W-1:0] d;
    for (int i = 0; i < 1500; i++) begin
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      d  = W'($urandom_range(0, 12));
      step(e, ld, d);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_d2();
    test_load5();
    test_last_wins();
    test_en_drop();
    test_stop_div();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
